// File: rtl/axi_rd_fsm_if.sv
// AXI4 read address and read data channels between a read master and axi_rd_fsm.
interface axi_rd_fsm_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_fsm.sv
// AXI4 read responder: one burst at a time, beats popped from the varint-out or raw-data-out FIFO.
// Optional RD_EMPTY_TIMEOUT_EN: an empty source FIFO returns an SLVERR beat after 65535 cycles.
module axi_rd_fsm #(
    parameter int SEL_BIT = 12,
    parameter int ID_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    axi_rd_fsm_if.slave axs_s0,
    input  logic        varint_out_fifo_empty,
    input  logic [31:0] varint_out_fifo_rdata,
    output logic        varint_out_fifo_pop,
    input  logic        raw_data_out_fifo_empty,
    input  logic [31:0] raw_data_out_fifo_rdata,
    output logic        raw_data_out_fifo_pop,
    output logic [7:0]  beat_index
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    typedef enum logic [3:0] {
        INIT     = 4'b0001,
        AR_READY = 4'b0010,
        R_FETCH  = 4'b0100,
        R_VALID  = 4'b1000
    } state_t;

    state_t          state_q;
    logic            arready_q;
    logic            rvalid_q;
    logic            rlast_q;
    logic [1:0]      rresp_q;
    logic [31:0]     rdata_q;
    logic            vpop_q;
    logic            rpop_q;
    logic [7:0]      beat_q;
    logic [ID_W-1:0] id_q;
    logic [7:0]      len_q;
    logic [2:0]      size_q;
    logic            sel_q;

    logic            src_empty;
    logic [31:0]     src_rdata;
    logic            last_beat;
    logic            fetch_err;
    logic            tmo_hit;
    logic            unused_ar;

    assign src_empty = sel_q ? raw_data_out_fifo_empty : varint_out_fifo_empty;
    assign src_rdata = sel_q ? raw_data_out_fifo_rdata : varint_out_fifo_rdata;
    assign last_beat = (beat_q == len_q);
    assign unused_ar = ^{axs_s0.arburst, axs_s0.araddr};

`ifdef RD_EMPTY_TIMEOUT_EN
    logic [15:0] tmo_q;

    // Zero outside R_FETCH, so every beat starts its wait from a cleared count.
    always_ff @(posedge clk) begin
        if (!reset || state_q != R_FETCH) begin
            tmo_q <= '0;
        end else if (src_empty) begin
            tmo_q <= tmo_q + 16'd1;
        end
    end
    assign tmo_hit = (tmo_q == 16'hFFFE);
`else
    assign tmo_hit = 1'b0;
`endif

    assign fetch_err = (size_q != SIZE_WORD) || (src_empty && tmo_hit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= INIT;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            vpop_q    <= 1'b0;
            rpop_q    <= 1'b0;
            beat_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            size_q    <= '0;
            sel_q     <= 1'b0;
        end else begin
            vpop_q <= 1'b0;
            rpop_q <= 1'b0;
            unique case (state_q)
                INIT: begin
                    state_q <= AR_READY;
                end
                AR_READY: begin
                    if (!arready_q) begin
                        arready_q <= 1'b1;
                    end else if (axs_s0.arvalid) begin
                        id_q      <= axs_s0.arid;
                        len_q     <= axs_s0.arlen;
                        size_q    <= axs_s0.arsize;
                        sel_q     <= axs_s0.araddr[SEL_BIT];
                        beat_q    <= '0;
                        arready_q <= 1'b0;
                        state_q   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // Bad beat size or timed-out wait: answer with an error beat, no pop.
                    if (fetch_err) begin
                        rdata_q  <= '0;
                        rresp_q  <= RESP_SLVERR;
                        rlast_q  <= last_beat;
                        rvalid_q <= 1'b1;
                        state_q  <= R_VALID;
                    end else if (!src_empty) begin
                        vpop_q   <= ~sel_q;
                        rpop_q   <= sel_q;
                        rdata_q  <= src_rdata;
                        rresp_q  <= RESP_OKAY;
                        rlast_q  <= last_beat;
                        rvalid_q <= 1'b1;
                        state_q  <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (axs_s0.rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            state_q   <= AR_READY;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            state_q <= R_FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign axs_s0.arready      = arready_q;
    assign axs_s0.rid          = id_q;
    assign axs_s0.rdata        = rdata_q;
    assign axs_s0.rresp        = rresp_q;
    assign axs_s0.rlast        = rlast_q;
    assign axs_s0.rvalid       = rvalid_q;
    assign varint_out_fifo_pop = vpop_q;
    assign raw_data_out_fifo_pop = rpop_q;
    assign beat_index          = beat_q;
endmodule

// File: tb/tb_axi_rd_fsm.sv
// Randomized bench for axi_rd_fsm: the bench plays both FIFOs and checks every beat against a queue model.
module tb_axi_rd_fsm;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi_rd_fsm_if #(.ID_W(4)) axs ();

    logic        v_empty, r_empty, v_pop, r_pop;
    logic [31:0] v_rdata, r_rdata;
    logic [7:0]  beat_index;

    axi_rd_fsm #(.SEL_BIT(12), .ID_W(4)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .axs_s0                  (axs),
        .varint_out_fifo_empty   (v_empty),
        .varint_out_fifo_rdata   (v_rdata),
        .varint_out_fifo_pop     (v_pop),
        .raw_data_out_fifo_empty (r_empty),
        .raw_data_out_fifo_rdata (r_rdata),
        .raw_data_out_fifo_pop   (r_pop),
        .beat_index              (beat_index)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // phys_* is what the DUT sees; mdl_* is the order words must come back in.
    logic [31:0] phys_v[$], phys_r[$], mdl_v[$], mdl_r[$];
    logic [31:0] log_d[$];
    logic [1:0]  log_resp[$];
    logic        log_last[$];

    bit         burst_active = 0;
    bit         last_done = 0;
    bit         expect_tmo = 0;
    logic [3:0] b_id;
    bit         b_sel;
    int         b_len, beat_no, pops, done_cnt = 0, vpop_tot = 0, rpop_tot = 0;
    logic [2:0] b_size;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void refresh();
        v_empty = (phys_v.size() == 0);
        r_empty = (phys_r.size() == 0);
        v_rdata = v_empty ? 32'h0 : phys_v[0];
        r_rdata = r_empty ? 32'h0 : phys_r[0];
    endfunction

    function automatic void push(bit sel, logic [31:0] w);
        if (sel) begin
            phys_r.push_back(w);
            mdl_r.push_back(w);
        end else begin
            phys_v.push_back(w);
            mdl_v.push_back(w);
        end
        refresh();
    endfunction

    function automatic void flush_model();
        phys_v.delete(); phys_r.delete(); mdl_v.delete(); mdl_r.delete();
        burst_active = 0;
        axs.arvalid = 1'b0;
        refresh();
    endfunction

    task automatic check_beat();
        logic [31:0] ed;
        logic [1:0]  er;
        bit          have;
        if (!burst_active) begin
            chk1("beat_unexpected", 1'b1, 1'b0);
        end else begin
            have = 1;
            if (b_size != 3'd2 || expect_tmo) begin
                ed = 32'h0; er = 2'b10;
            end else begin
                er = 2'b00;
                if (b_sel && mdl_r.size() > 0) ed = mdl_r.pop_front();
                else if (!b_sel && mdl_v.size() > 0) ed = mdl_v.pop_front();
                else begin ed = 32'h0; have = 0; end
            end
            $display("beat id=%0d idx=%0d data=%08h resp=%0d last=%0b", axs.rid, beat_index,
                     axs.rdata, axs.rresp, axs.rlast);
            chk1("model_has_word", have, 1'b1);
            chk("rdata", axs.rdata, ed);
            chk("rresp", 32'(axs.rresp), 32'(er));
            chk("rid", 32'(axs.rid), 32'(b_id));
            chk1("rlast", axs.rlast, beat_no == b_len);
            chk("beat_index", 32'(beat_index), beat_no);
            log_d.push_back(axs.rdata);
            log_resp.push_back(axs.rresp);
            log_last.push_back(axs.rlast);
            beat_no++;
            if (beat_no == b_len + 1) begin
                chk("pop_count", pops, (b_size == 3'd2 && !expect_tmo) ? b_len + 1 : 0);
                burst_active = 0;
                last_done = 1;
                done_cnt++;
            end
        end
    endtask

    // One clock: evaluate handshakes before the edge, then check outputs 1 time unit after it.
    task automatic tick();
        bit          ar_hs, r_hs, rst_pre, hv;
        logic [31:0] hd;
        logic        hl;
        logic [1:0]  hr;
        rst_pre = reset;
        ar_hs = rst_pre && axs.arvalid && axs.arready;
        r_hs  = rst_pre && axs.rvalid && axs.rready;
        hv    = rst_pre && axs.rvalid && !axs.rready;
        hd = axs.rdata; hl = axs.rlast; hr = axs.rresp;
        last_done = 0;
        if (r_hs) check_beat();
        if (ar_hs) begin
            burst_active = 1;
            b_id = axs.arid; b_sel = axs.araddr[12]; b_len = int'(axs.arlen);
            b_size = axs.arsize; beat_no = 0; pops = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ar_hs) axs.arvalid = 1'b0;
        if (!rst_pre) begin
            flush_model();
        end else begin
            if (last_done) chk1("arready_reassert", axs.arready, 1'b1);
            else if (burst_active) chk1("arready_busy", axs.arready, 1'b0);
            if (hv) begin
                chk1("hold_rvalid", axs.rvalid, 1'b1);
                chk("hold_rdata", axs.rdata, hd);
                chk1("hold_rlast", axs.rlast, hl);
                chk("hold_rresp", 32'(axs.rresp), 32'(hr));
            end
            if (v_pop) begin
                vpop_tot++; pops++;
                chk1("varint_pop_legal", burst_active && !b_sel && b_size == 3'd2, 1'b1);
                if (phys_v.size() > 0) void'(phys_v.pop_front());
                else chk1("varint_pop_empty", 1'b1, 1'b0);
            end
            if (r_pop) begin
                rpop_tot++; pops++;
                chk1("raw_pop_legal", burst_active && b_sel && b_size == 3'd2, 1'b1);
                if (phys_r.size() > 0) void'(phys_r.pop_front());
                else chk1("raw_pop_empty", 1'b1, 1'b0);
            end
            refresh();
        end
    endtask

    task automatic issue(logic [3:0] id, bit sel, logic [7:0] len, logic [2:0] size);
        logic [31:0] a;
        a = $urandom;
        a[12] = sel;
        axs.arid = id; axs.araddr = a; axs.arlen = len; axs.arsize = size;
        axs.arburst = 2'($urandom);
        axs.arvalid = 1'b1;
    endtask

    task automatic wait_ar(int budget);
        int c = 0;
        while (axs.arvalid && c < budget) begin tick(); c++; end
        chk1("ar_handshake_timeout", axs.arvalid, 1'b0);
    endtask

    task automatic wait_done(int target, int budget, bit rnd);
        int c = 0;
        bit s;
        while (done_cnt < target && c < budget) begin
            if (rnd) begin
                if ($urandom_range(1, 0) == 1) begin
                    s = (burst_active && $urandom_range(3, 0) != 0) ? b_sel : 1'($urandom);
                    if ((s ? phys_r.size() : phys_v.size()) < 24) push(s, $urandom);
                end
                axs.rready = ($urandom_range(3, 0) != 0);
            end
            tick(); c++;
        end
        chk("burst_timeout", done_cnt, target);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        chk1("rst_arready", axs.arready, 1'b0);
        chk1("rst_rvalid", axs.rvalid, 1'b0);
        chk1("rst_rlast", axs.rlast, 1'b0);
        chk("rst_rdata", axs.rdata, 32'h0);
        chk("rst_rid", 32'(axs.rid), 32'h0);
        chk("rst_rresp", 32'(axs.rresp), 32'h0);
        chk("rst_beat_index", 32'(beat_index), 32'h0);
        chk1("rst_pops", v_pop | r_pop, 1'b0);
        reset = 1'b1;
        tick();
        chk1("rel_arready_1", axs.arready, 1'b0);
        tick();
        chk1("rel_arready_2", axs.arready, 1'b1);
    endtask

    initial begin
        int vp, rp, c;
        axs.arid = '0; axs.araddr = '0; axs.arlen = '0; axs.arsize = 3'd2; axs.arburst = '0;
        axs.arvalid = 1'b0; axs.rready = 1'b0;
        refresh();
        do_reset();

        // Four varint words, id 3.
        log_d.delete(); log_last.delete(); log_resp.delete();
        vp = vpop_tot; rp = rpop_tot;
        for (int i = 0; i < 4; i++) push(0, 32'hA0 + i);
        axs.rready = 1'b1;
        issue(4'd3, 0, 8'd3, 3'd2);
        wait_done(done_cnt + 1, 200, 0);
        chk("t1_beats", log_d.size(), 4);
        for (int i = 0; i < 4 && i < log_d.size(); i++) begin
            chk("t1_data", log_d[i], 32'hA0 + i);
            chk1("t1_last", log_last[i], i == 3);
        end
        chk("t1_varint_pops", vpop_tot - vp, 4);
        chk("t1_raw_pops", rpop_tot - rp, 0);

        // Single raw beat, latency and arready return.
        log_d.delete();
        push(1, 32'hDEADBEEF);
        issue(4'd5, 1, 8'd0, 3'd2);
        wait_ar(20);
        chk1("lat_fetch", axs.rvalid, 1'b0);
        tick();
        chk1("lat_valid", axs.rvalid, 1'b1);
        chk1("t2_rlast", axs.rlast, 1'b1);
        tick();
        chk1("t2_arready", axs.arready, 1'b1);
        chk("t2_data", log_d.size() > 0 ? log_d[0] : 32'h0, 32'hDEADBEEF);

        // Illegal beat size: two error beats, no pops.
        log_resp.delete();
        vp = vpop_tot;
        push(0, 32'h1234);
        issue(4'd9, 0, 8'd1, 3'd1);
        wait_done(done_cnt + 1, 200, 0);
        chk("t3_beats", log_resp.size(), 2);
        for (int i = 0; i < 2 && i < log_resp.size(); i++) chk("t3_resp", 32'(log_resp[i]), 32'h2);
        chk("t3_pops", vpop_tot - vp, 0);

        // Empty FIFO stall for 20 cycles (leftover 0x1234 drained first).
        flush_model();
        log_d.delete();
        issue(4'd1, 0, 8'd0, 3'd2);
        wait_ar(20);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("stall_rvalid", axs.rvalid, 1'b0);
        end
        push(0, 32'h55);
        wait_done(done_cnt + 1, 50, 0);
        chk("stall_data", log_d.size() > 0 ? log_d[0] : 32'h0, 32'h55);

        // rready low for 10 cycles while a beat is presented.
        vp = vpop_tot;
        push(0, 32'h77); push(0, 32'h78);
        axs.rready = 1'b0;
        issue(4'd2, 0, 8'd1, 3'd2);
        c = 0;
        while (!axs.rvalid && c < 50) begin tick(); c++; end
        chk1("hold_reach_rvalid", axs.rvalid, 1'b1);
        repeat (10) tick();
        chk("hold_pops", vpop_tot - vp, 1);
        axs.rready = 1'b1;
        wait_done(done_cnt + 1, 50, 0);

        // Reset at beat 2 of an 8-beat burst.
        for (int i = 0; i < 8; i++) push(0, 32'hC0 + i);
        issue(4'd4, 0, 8'd7, 3'd2);
        c = 0;
        while (!(axs.rvalid && beat_index == 8'd2) && c < 100) begin tick(); c++; end
        chk("mid_reach_beat2", 32'(beat_index), 32'd2);
        reset = 1'b0;
        tick();
        chk1("mid_rvalid", axs.rvalid, 1'b0);
        chk1("mid_arready", axs.arready, 1'b0);
        reset = 1'b1;
        tick();
        chk1("mid_rel_arready_1", axs.arready, 1'b0);
        tick();
        chk1("mid_rel_arready_2", axs.arready, 1'b1);

        // 256-beat burst from the raw FIFO.
        log_last.delete();
        for (int i = 0; i < 256; i++) push(1, 32'(i * 3 + 7));
        issue(4'd7, 1, 8'd255, 3'd2);
        wait_done(done_cnt + 1, 3000, 0);
        chk("long_beats", log_last.size(), 256);
        if (log_last.size() == 256) begin
            chk1("long_last_254", log_last[254], 1'b0);
            chk1("long_last_255", log_last[255], 1'b1);
        end

        // Random bursts with random FIFO fill and rready.
        for (int b = 0; b < 40; b++) begin
            issue(4'($urandom), 1'($urandom),
                  ($urandom_range(7, 0) == 0) ? 8'($urandom_range(31, 0)) : 8'($urandom_range(5, 0)),
                  ($urandom_range(5, 0) == 0) ? 3'd1 : 3'd2);
            wait_done(done_cnt + 1, 3000, 1);
        end
        axs.rready = 1'b1;

`ifdef RD_EMPTY_TIMEOUT_EN
        flush_model();
        log_resp.delete();
        expect_tmo = 1;
        issue(4'd6, 0, 8'd0, 3'd2);
        wait_ar(20);
        c = 0;
        while (!axs.rvalid && c < 70000) begin tick(); c++; end
        chk("tmo_cycles", c, 65535);
        wait_done(done_cnt + 1, 10, 0);
        chk("tmo_resp", log_resp.size() > 0 ? 32'(log_resp[0]) : 32'h0, 32'h2);
        expect_tmo = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_rd_fsm.md
Name: axi_rd_fsm

Overview:
- AXI4 read-channel responder for the accelerator's output side.
- Accepts a single read burst, pops 32-bit words from one of two output FIFOs (varint-out or raw-data-out, chosen by address bit), and returns them on the R channel.
- It is the read-direction counterpart of the AXI4 write-slave FSM that pushes into the input FIFOs.
- One burst is outstanding at a time. There is no read interleaving.

Parameters:
- SEL_BIT, 12: araddr bit that selects the source FIFO (0 = varint-out, 1 = raw-data-out).
- ID_W, 4: AXI ID width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- axs_s0_arid  in  ID_W  read burst ID
- axs_s0_araddr  in  32  read address; only bit SEL_BIT is used
- axs_s0_arlen  in  8  beats minus 1
- axs_s0_arsize  in  3  beat size; 3'd2 is the only legal value
- axs_s0_arburst  in  2  ignored (FIFO semantics)
- axs_s0_arvalid  in  1  address valid
- axs_s0_arready  out  1  address ready
- axs_s0_rid  out  ID_W  latched arid
- axs_s0_rdata  out  32  read data
- axs_s0_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- axs_s0_rlast  out  1  last beat of burst
- axs_s0_rvalid  out  1  read data valid
- axs_s0_rready  in  1  master ready
- varint_out_fifo_empty  in  1  source FIFO empty
- varint_out_fifo_rdata  in  32  first-word-fall-through head
- varint_out_fifo_pop  out  1  one-cycle pop strobe
- raw_data_out_fifo_empty  in  1  source FIFO empty
- raw_data_out_fifo_rdata  in  32  first-word-fall-through head
- raw_data_out_fifo_pop  out  1  one-cycle pop strobe
- beat_index  out  8  current beat number within the burst

Behaviour:
- Outputs are registered. State encoding is one-hot: INIT, AR_READY, R_FETCH, R_VALID.
- On reset low: state = INIT. arready, rvalid, rlast, both pops = 0. rdata, rid, rresp, beat_index = 0. Latched burst fields = 0.
- INIT: one cycle, then go to AR_READY. arready = 1 from the cycle after entry.
- AR_READY: hold arready = 1 until arvalid.
  - On arvalid & arready: latch arid, arlen, arsize and araddr[SEL_BIT]. Set beat_index = 0, arready = 0, go to R_FETCH.
- R_FETCH:
  - Selected FIFO not empty: assert its pop for exactly one cycle and capture its rdata into axs_s0_rdata. Set rresp = OKAY, rlast = (beat_index == arlen), rvalid = 1, go to R_VALID.
  - Selected FIFO empty: stay in R_FETCH with rvalid = 0 and no pop. The stall is unbounded unless the optional feature is enabled.
  - Latched arsize != 2: do not pop. Set rdata = 0, rresp = SLVERR, rvalid = 1. The burst still runs for arlen+1 beats.
- R_VALID: hold rdata, rresp, rlast and rvalid stable until rready.
  - On rvalid & rready with rlast = 1: rvalid = 0, arready = 1, go to AR_READY.
  - On rvalid & rready with rlast = 0: beat_index += 1, rvalid = 0, go to R_FETCH.
- Throughput is one beat per 2 cycles minimum. Latency from the AR handshake to the first rvalid is 2 cycles when the FIFO is non-empty.
- The unselected FIFO is never popped. A pop only ever occurs in R_FETCH.
- arlen = 255 gives 256 beats. beat_index is 8 bits, and rlast fires at beat_index == 255 with no wrap.
- Reset low mid-burst: return to INIT immediately and drop the remaining beats. Already-popped data is lost.
- arvalid is not sampled outside AR_READY. arready is never asserted while a burst is active.

Optional Feature:
- RD_EMPTY_TIMEOUT_EN defined: R_FETCH runs a 16-bit counter that is cleared on entry.
  - If the selected FIFO stays empty for 65535 cycles, return the current beat with rdata = 0 and rresp = SLVERR, then continue the burst normally.
  - Every later beat of that burst also waits at most 65535 cycles.
- RD_EMPTY_TIMEOUT_EN undefined: no counter, and an empty FIFO stalls indefinitely.

Test Plan:
- Reset, then AR arid=3, araddr bit12=0, arlen=3, arsize=2, with varint FIFO holding 0xA0..0xA3 and rready=1 → 4 beats rdata 0xA0..0xA3, rid=3, rresp=0, rlast only on beat 3. varint pop pulses 4 times. raw pop never fires.
- araddr bit12=1, arlen=0 with raw FIFO = 0xDEADBEEF → single beat, rlast=1, rdata=0xDEADBEEF. arready reasserts the cycle after the R handshake.
- arsize=1, arlen=1 → 2 beats, rresp=2'b10, rdata=0, zero pops.
- FIFO empty for 20 cycles after the AR handshake, then one word 0x55 is pushed → rvalid stays low for 20 cycles, then one beat 0x55. With RD_EMPTY_TIMEOUT_EN and the FIFO never filled → SLVERR beat after 65535 cycles.
- rready held low for 10 cycles in R_VALID → rdata and rlast stable, no extra pop. Reset low at beat 2 of an arlen=7 burst → rvalid=0 next cycle, arready=1 two cycles after reset release.
